// File: rtl/seq_det_pkg.sv
// seq_det_pkg: KMP helpers that build the detector transition table
// at elaboration time from the pattern constant.
package seq_det_pkg;

  localparam int MAX_W = 16;

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int kmp_fail(
    input logic [MAX_W-1:0] pattern,
    input int               width
  );
    int f;
    bit ok;
    f = 0;
    for (int k = width - 1; k >= 1; k--) begin
      if (f == 0) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (pattern[width-1-i] != pattern[k-1-i]) ok = 1'b0;
        if (ok) f = k;
      end
    end
    return f;
  endfunction

  // Longest pattern prefix that ends the received string
  // (state matched bits followed by b), capped below a full match.
  function automatic int kmp_next(
    input logic [MAX_W-1:0] pattern,
    input int               width,
    input int               state,
    input logic             b
  );
    int   len;
    int   top;
    int   nxt;
    bit   ok;
    logic sb;
    len = state + 1;
    top = (len < width) ? len : width - 1;
    nxt = 0;
    for (int k = top; k >= 1; k--) begin
      if (nxt == 0) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          sb = (len - k + i == state) ? b
             : pattern[width-1-(len-k+i)];
          if (sb != pattern[width-1-i]) ok = 1'b0;
        end
        if (ok) nxt = k;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seq_det_param_sat_cnt.sv
// seq_det_sat_cnt: CNT_W-bit saturating up-counter, clear beats
// increment, synchronous active-high reset.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && cnt != {CNT_W{1'b1}})
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial pattern detector (KMP FSM).
// Match counter is built only when SEQ_DET_CNT_EN is defined.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int         PAT_W   = 4,
  parameter logic [15:0] PATTERN = 16'b1011,
  parameter bit         OVERLAP = 1'b1,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cnt_clr,
  output logic             det,
  output logic             det_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam int NS = 2 ** SW;
  localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);
  localparam logic [SW-1:0] FB_S =
    SW'(kmp_fail(PATTERN, PAT_W));

  if (PAT_W < 2 || PAT_W > MAX_W) begin : g_bad_w
    $error("seq_det_param: PAT_W must be 2..16");
  end
  if ((PATTERN >> PAT_W) != 16'd0) begin : g_bad_pat
    $error("seq_det_param: PATTERN wider than PAT_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_det_param: CNT_W must be >= 1");
  end

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  logic [SW-1:0] s_q;

  // Unreachable encodings fall back to idle.
  for (genvar s = 0; s < NS; s++) begin : g_tbl
    if (s < PAT_W) begin : g_live
      assign nxt0[s] = SW'(kmp_next(PATTERN, PAT_W, s, 1'b0));
      assign nxt1[s] = SW'(kmp_next(PATTERN, PAT_W, s, 1'b1));
    end else begin : g_dead
      assign nxt0[s] = '0;
      assign nxt1[s] = '0;
    end
  end

  assign det = in_valid & (s_q == LAST)
             & (in == PATTERN[0]) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else if (in_valid) begin
      if (det)
        s_q <= OVERLAP ? FB_S : '0;
      else
        s_q <= in ? nxt1[s_q] : nxt0[s_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      det_q <= 1'b0;
    else
      det_q <= det;
  end

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(det),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: four detector configurations share one stream;
// a windowed-history model feeds a scoreboard checked at negedge.
module tb_seq_det_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int         W   [4] = '{4, 4, 4, 8};
  localparam bit [15:0]  PAT [4] = '{16'hB, 16'hB, 16'hB, 16'hA5};
  localparam bit         OV  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int         CW  [4] = '{8, 8, 2, 8};

  typedef struct packed {
    logic [3:0]      det;
    logic [3:0]      detq;
    logic [3:0][7:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, cnt_clr;
  logic [3:0] det_v, detq_v;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;

  always #5 clk = ~clk;

  seq_det_param u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cnt_clr(cnt_clr), .det(det_v[0]), .det_q(detq_v[0]),
    .match_cnt(c0)
  );
  seq_det_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cnt_clr(cnt_clr), .det(det_v[1]), .det_q(detq_v[1]),
    .match_cnt(c1)
  );
  seq_det_param #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cnt_clr(cnt_clr), .det(det_v[2]), .det_q(detq_v[2]),
    .match_cnt(c2)
  );
  seq_det_param #(.PAT_W(8), .PATTERN(16'hA5)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cnt_clr(cnt_clr), .det(det_v[3]), .det_q(detq_v[3]),
    .match_cnt(c3)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int det_seen [4];
  int ref_dets [4];

  bit [15:0] hist [4];
  int        hlen [4];
  int        mcnt [4];
  bit        pdet [4];
  rec_t      sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  function automatic int cnt_of(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  // Model: keep the bits received since reset (or since the last
  // non-overlapping match); a match is the last W bits equal PAT.
  task automatic step(input bit r, input bit v, input bit b, input bit c);
    rec_t      e;
    bit [15:0] nh, mask;
    int        nl;
    bit        d;
    rst = r; in_valid = v; in_bit = b; cnt_clr = c;
    for (int i = 0; i < 4; i++) begin
      nh   = {hist[i][14:0], b};
      nl   = (hlen[i] < 16) ? hlen[i] + 1 : 16;
      mask = 16'((32'd1 << W[i]) - 1);
      d    = !r && v && nl >= W[i] && ((nh & mask) == PAT[i]);
      e.det[i]  = d;
      e.detq[i] = pdet[i];
      e.cnt[i]  = 8'(mcnt[i]);
      if (d) ref_dets[i]++;
      if (r) begin
        hist[i] = '0; hlen[i] = 0; mcnt[i] = 0;
      end else begin
        if (v) begin
          hist[i] = nh;
          hlen[i] = (d && !OV[i]) ? 0 : nl;
        end
        if (CNT_EN) begin
          if (c) mcnt[i] = 0;
          else if (d && mcnt[i] < (1 << CW[i]) - 1) mcnt[i]++;
        end
      end
      pdet[i] = d;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input bit [31:0] bits, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, bits[n-1-k], 1'b0);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 4; i++) begin
      det_seen[i] = 0;
      ref_dets[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("det%0d", i), int'(det_v[i]), int'(e.det[i]));
        check($sformatf("det_q%0d", i), int'(detq_v[i]), int'(e.detq[i]));
        check($sformatf("cnt%0d", i), cnt_of(i), int'(e.cnt[i]));
        if (det_v[i]) det_seen[i]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      hist[i] = '0; hlen[i] = 0; mcnt[i] = 0; pdet[i] = 1'b0;
    end
    clear_seen();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_det_q", int'(detq_v[0]), 0);
    check("rst_cnt", int'(c0), 0);

    clear_seen();
    stream(32'b10101101011, 11);
    check("s1_dets", det_seen[0], 2);
    check("s1_cnt", int'(c0), CNT_EN ? 2 : 0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    clear_seen();
    stream(32'b1011011, 7);
    check("ov1_dets", det_seen[0], 2);
    check("ov0_dets", det_seen[1], 1);
    check("ov0_cnt", int'(c1), CNT_EN ? 1 : 0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    clear_seen();
    stream(32'b101, 3);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
    stream(32'b1, 1);
    check("gap_dets", det_seen[0], 1);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    clear_seen();
    stream(32'b101, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    stream(32'b1, 1);
    check("rst_mid_dets", det_seen[0], 0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    stream(32'b1, 1);
    for (int k = 0; k < 7; k++) stream(32'b011, 3);
    check("sat_cnt2", int'(c2), CNT_EN ? 3 : 0);
    stream(32'b01, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_wins", int'(c0), 0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    clear_seen();
    for (int k = 0; k < 1000; k++)
      step(1'b0, ($urandom % 8) != 0, 1'($urandom),
           ($urandom % 50) == 0);
    check("a5_dets", det_seen[3], ref_dets[3]);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
